apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- Parametrised APB (AMBA3-style) slave register file; successor to the fixed 16x32 APB slave.
- Configurable data width, address width and register depth.
- Per-transfer programmable wait states.
- PSLVERR on out-of-range addresses.
- Sits behind the APB bridge as a generic scratch/config register block.

Parameters:
DATA_W, 32, data bus width in bits (multiple of 8)
ADDR_W, 4, paddr_i width; word index, not byte address
DEPTH, 16, number of registers; must satisfy DEPTH <= 2**ADDR_W
WAIT_W, 4, width of wait-state count input

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
paddr_i  in  ADDR_W  register word index
pwrite_i  in  1  1 = write, 0 = read
pwdata_i  in  DATA_W  write data
wait_cfg_i  in  WAIT_W  wait states to insert; sampled at setup
prdata_o  out  DATA_W  read data; valid only while pready_o=1 and pwrite_i=0
pready_o  out  1  transfer completes this cycle
pslverr_o  out  1  error response; valid only while pready_o=1

Behaviour:
- Reset:
  - Asynchronous reset: FSM goes to IDLE, wait counter goes to 0, all DEPTH registers clear to 0.
  - Outputs while reset is high: prdata_o=0, pready_o=0, pslverr_o=0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - pready_o=0.
  - On a posedge with psel_i=1, latch cnt <= wait_cfg_i and go to ACCESS.
  - penable_i is ignored here. This keeps legacy masters that raise psel/penable together working; they see one extra cycle.
- ACCESS:
  - pready_o = (cnt==0). This is a combinational decode of registered state; no dependence on the current cycle's bus inputs.
  - cnt!=0 at a posedge: cnt decrements.
  - Access phase therefore lasts wait_cfg+1 cycles after setup.
  - Completion edge is a posedge with psel_i=1, penable_i=1, pready_o=1. At that edge:
    - write and addr < DEPTH: mem[paddr_i] <= pwdata_i.
    - FSM returns to IDLE. Back-to-back transfers need a fresh setup cycle, i.e. a minimum of 2 cycles per transfer.
  - pready_o=1 but penable_i=0: stay in ACCESS; pready_o stays high until the master asserts penable_i.
  - psel_i=0 in ACCESS (abort): return to IDLE at that edge; no write; cnt discarded.
- Read data:
  - prdata_o = mem[paddr_i] when pready_o=1, pwrite_i=0 and paddr_i < DEPTH; otherwise 0.
  - Same-cycle combinational read from the register array.
- Error:
  - pslverr_o = pready_o & (paddr_i >= DEPTH).
  - On error: writes are dropped and prdata_o=0.
  - With DEPTH == 2**ADDR_W, pslverr_o is constant 0.
- Address and data stability from setup to completion is the master's responsibility. The slave uses current-cycle paddr_i, pwrite_i and pwdata_i.
- Reset asserted mid-transfer: immediate return to IDLE, registers cleared; the in-flight write is lost.
- wait_cfg_i changing during ACCESS has no effect until the next setup.

Optional Feature:
APB_PSTRB_EN
- Defined:
  - Adds input pstrb_i [DATA_W/8-1:0].
  - On a write completion, only byte lanes with pstrb_i[k]=1 are updated; the other lanes keep their old value.
  - pstrb_i is ignored on reads.
- Undefined: the port is absent and all writes update the full word.

Test Plan:
- Reset and idle: reset high for 2 cycles, then release. Read every address 0..15 with wait_cfg=0. Each read completes 2 cycles after psel, prdata_o=0, pslverr_o=0.
- Zero-wait write/read: write 0xDEADBEEF to addr 5 with wait_cfg=0; pready_o is high in the first access cycle. Read back addr 5 gives 0xDEADBEEF; addr 4 still reads 0.
- Wait states: write with wait_cfg=3. pready_o is low for exactly 3 access cycles and high on the 4th; the register updates only on that completing edge.
- Out of range: DEPTH=12. Write 0x1234 to addr 13, then read addr 13. Both give pslverr_o=1 with pready_o=1; prdata_o=0; registers 0..11 unchanged.
- Abort and async reset:
  - Abort: start a write of 0xAAAA to addr 2 with wait_cfg=5, drop psel_i after 2 access cycles. addr 2 keeps its old value and the FSM is in IDLE.
  - Async reset: assert reset asynchronously mid-transfer. pready_o drops immediately; all registers read 0 after release.
- APB_PSTRB_EN: write 0xFFFFFFFF to addr 1, then write 0x00000000 with pstrb_i=4'b0101. Read of addr 1 gives 0xFF00FF00.

Source files
------------

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle for apb_slave_regfile; pstrb_i exists only when APB_PSTRB_EN is defined.
`timescale 1ns / 1ps

interface apb_slave_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WAIT_W = 4
);
    logic              psel_i;
    logic              penable_i;
    logic [ADDR_W-1:0] paddr_i;
    logic              pwrite_i;
    logic [DATA_W-1:0] pwdata_i;
    logic [WAIT_W-1:0] wait_cfg_i;
`ifdef APB_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb_i;
`endif
    logic [DATA_W-1:0] prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, wait_cfg_i,
`ifdef APB_PSTRB_EN
        output pstrb_i,
`endif
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, wait_cfg_i,
`ifdef APB_PSTRB_EN
        input  pstrb_i,
`endif
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// Parametrised APB register file with per-transfer wait states and PSLVERR on out-of-range words.
// Define APB_PSTRB_EN to enable byte-lane write strobes (pstrb_i).
`timescale 1ns / 1ps

module apb_slave_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WAIT_W = 4
) (
    input logic                clk,
    input logic                reset,
    apb_slave_regfile_if.slave apb_io
);
    localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned StrbW = DATA_W / 8;

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              addr_ok;
    logic              pready;
    logic              wr_en;
    logic [IdxW-1:0]   idx;
    logic [DATA_W-1:0] wr_data;

    assign addr_ok = (32'(apb_io.paddr_i) < DEPTH);
    assign idx     = apb_io.paddr_i[IdxW-1:0];
    assign pready  = (state_q == StAccess) && (cnt_q == '0);

    assign apb_io.pready_o  = pready;
    assign apb_io.pslverr_o = pready & ~addr_ok;
    assign apb_io.prdata_o  = (pready && !apb_io.pwrite_i && addr_ok) ? mem_q[idx] : '0;

    always_comb begin
        wr_data = apb_io.pwdata_i;
`ifdef APB_PSTRB_EN
        for (int k = 0; k < StrbW; k++) begin
            if (!apb_io.pstrb_i[k]) begin
                wr_data[8*k +: 8] = mem_q[idx][8*k +: 8];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // penable_i ignored so masters raising psel/penable together still work.
                if (apb_io.psel_i) begin
                    cnt_d   = apb_io.wait_cfg_i;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!apb_io.psel_i) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (apb_io.penable_i) begin
                    wr_en   = apb_io.pwrite_i & addr_ok;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= wr_data;
        end
    end

    logic unused_strb;
    assign unused_strb = (StrbW == 0);
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile (DEPTH=12 so out-of-range words are reachable).
`timescale 1ns / 1ps

module tb_apb_slave_regfile;
    localparam int unsigned DataW  = 32;
    localparam int unsigned AddrW  = 4;
    localparam int unsigned Depth  = 12;
    localparam int unsigned WaitW  = 4;
    localparam int          Budget = 40;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] model_mem [16];
    exp_t        sb_q [$];
    int          n_checks;
    int          n_errors;

    apb_slave_regfile_if #(.DATA_W(DataW), .ADDR_W(AddrW), .WAIT_W(WaitW)) bus ();

    apb_slave_regfile #(
        .DATA_W(DataW),
        .ADDR_W(AddrW),
        .DEPTH (Depth),
        .WAIT_W(WaitW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .apb_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge with the bus idle; returns #1 after a posedge with the bus idle.
    task automatic xfer(input logic [3:0] addr, input logic wr, input logic [31:0] data,
                        input logic [3:0] wt, input logic [3:0] strb, input string tag);
        exp_t e;
        exp_t got_e;
        int   n;
        logic ok;
        ok      = (32'(addr) < Depth);
        e.err   = !ok;
        e.rdata = (!wr && ok) ? model_mem[addr] : 32'h0;
        e.waits = int'(wt);
        sb_q.push_back(e);

        bus.psel_i     = 1'b1;
        bus.penable_i  = 1'b0;
        bus.paddr_i    = addr;
        bus.pwrite_i   = wr;
        bus.pwdata_i   = data;
        bus.wait_cfg_i = wt;
`ifdef APB_PSTRB_EN
        bus.pstrb_i    = strb;
`endif
        @(posedge clk);
        #1 bus.penable_i = 1'b1;
        n = 0;
        while (!bus.pready_o && n < Budget) begin
            @(posedge clk);
            #1 n++;
        end
        got_e = sb_q.pop_front();
        check({tag, " waits"}, 64'(n), 64'(got_e.waits));
        check({tag, " rdata"}, 64'(bus.prdata_o), 64'(got_e.rdata));
        check({tag, " slverr"}, 64'(bus.pslverr_o), 64'(got_e.err));
        if (wr && ok) begin
            for (int k = 0; k < 4; k++) begin
`ifdef APB_PSTRB_EN
                if (strb[k]) model_mem[addr][8*k +: 8] = data[8*k +: 8];
`else
                model_mem[addr][8*k +: 8] = data[8*k +: 8];
`endif
            end
        end
        @(posedge clk);
        #1 bus.psel_i = 1'b0;
        bus.penable_i = 1'b0;
        check({tag, " idle"}, 64'(bus.pready_o), 64'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
        bus.psel_i     = 1'b0;
        bus.penable_i  = 1'b0;
        bus.paddr_i    = '0;
        bus.pwrite_i   = 1'b0;
        bus.pwdata_i   = '0;
        bus.wait_cfg_i = '0;
`ifdef APB_PSTRB_EN
        bus.pstrb_i    = '1;
`endif
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst pready", 64'(bus.pready_o), 64'h0);
        check("rst pslverr", 64'(bus.pslverr_o), 64'h0);
        check("rst prdata", 64'(bus.prdata_o), 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int a = 0; a < 16; a++) xfer(4'(a), 1'b0, 32'h0, 4'd0, 4'hf, "rd_init");

        xfer(4'd5, 1'b1, 32'hDEADBEEF, 4'd0, 4'hf, "wr5");
        xfer(4'd5, 1'b0, 32'h0, 4'd0, 4'hf, "rd5");
        xfer(4'd4, 1'b0, 32'h0, 4'd0, 4'hf, "rd4");

        xfer(4'd7, 1'b1, 32'h0BADF00D, 4'd3, 4'hf, "wr7_w3");
        xfer(4'd7, 1'b0, 32'h0, 4'd2, 4'hf, "rd7_w2");

        xfer(4'd13, 1'b1, 32'h00001234, 4'd0, 4'hf, "wr13_oor");
        xfer(4'd13, 1'b0, 32'h0, 4'd1, 4'hf, "rd13_oor");
        for (int a = 0; a < 12; a++) xfer(4'(a), 1'b0, 32'h0, 4'd0, 4'hf, "rd_after_oor");

        // Abort: drop psel after two access cycles of a 5-wait write.
        xfer(4'd2, 1'b1, 32'h00001111, 4'd0, 4'hf, "wr2");
        bus.psel_i     = 1'b1;
        bus.penable_i  = 1'b0;
        bus.paddr_i    = 4'd2;
        bus.pwrite_i   = 1'b1;
        bus.pwdata_i   = 32'h0000AAAA;
        bus.wait_cfg_i = 4'd5;
        @(posedge clk);
        #1 bus.penable_i = 1'b1;
        check("abort wait1", 64'(bus.pready_o), 64'h0);
        @(posedge clk);
        #1 bus.psel_i = 1'b0;
        bus.penable_i = 1'b0;
        @(posedge clk);
        #1 check("abort idle", 64'(bus.pready_o), 64'h0);
        xfer(4'd2, 1'b0, 32'h0, 4'd0, 4'hf, "rd2_after_abort");

        // Asynchronous reset while pready is high on a write.
        bus.psel_i     = 1'b1;
        bus.penable_i  = 1'b0;
        bus.paddr_i    = 4'd5;
        bus.pwrite_i   = 1'b1;
        bus.pwdata_i   = 32'h55555555;
        bus.wait_cfg_i = 4'd0;
        @(posedge clk);
        #1 bus.penable_i = 1'b1;
        check("arst pre pready", 64'(bus.pready_o), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("arst pready", 64'(bus.pready_o), 64'h0);
        check("arst pslverr", 64'(bus.pslverr_o), 64'h0);
        check("arst prdata", 64'(bus.prdata_o), 64'h0);
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
        for (int a = 0; a < 12; a++) xfer(4'(a), 1'b0, 32'h0, 4'd0, 4'hf, "rd_after_arst");

`ifdef APB_PSTRB_EN
        xfer(4'd1, 1'b1, 32'hFFFFFFFF, 4'd0, 4'hf, "strb_full");
        xfer(4'd1, 1'b1, 32'h00000000, 4'd1, 4'b0101, "strb_0101");
        xfer(4'd1, 1'b0, 32'h0, 4'd0, 4'h0, "strb_rd");
        check("strb literal", 64'(model_mem[1]), 64'hFF00FF00);
`endif

        check("sb empty", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
